// File: rtl/lfsr_sng_et.sv
// Multi-channel LFSR stochastic number generator with start/stop handshake,
// programmable stream length, early termination and per-channel ones counts.
module lfsr_sng_et #(
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  LFSR_POLY   = WIDTH'(8'h1D),  // x^8+x^4+x^3+x^2+1, MSB implied
    parameter int                NUM_INPUTS  = 4,
    parameter int                CORR_MODE   = 0,
    parameter int                SEED_BASE   = 1,
    parameter int                SEED_STRIDE = 37
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [WIDTH:0]                      len,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0]    Bxs,
    input  logic                                stop,
    output logic [NUM_INPUTS-1:0]               Xs,
    output logic                                valid,
    output logic                                busy,
    output logic                                done,
    output logic [WIDTH:0]                      count,
    output logic [NUM_INPUTS-1:0][WIDTH:0]      ones,
    output logic [1:0]                          dbg_state
);

    // Handshake: start is accepted only in IDLE (busy=0); stop is honoured only
    // in RUN. Xs is meaningful exactly when valid=1; done marks the one DONE cycle.

    localparam int NUM_LFSR = (CORR_MODE != 0) ? 1 : NUM_INPUTS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] seed_of(input int i);
        return WIDTH'(SEED_BASE + i * SEED_STRIDE);
    endfunction

    // Galois step with a single zero data bit: feedback is just the MSB.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? LFSR_POLY : '0);
    endfunction

    for (genvar g = 0; g < NUM_LFSR; g++) begin : g_seed_chk
        if (seed_of(g) == '0) begin : g_zero_seed
            $error("lfsr_sng_et: an LFSR seed evaluates to zero");
        end
    end

    state_t                             state_q, state_d;
    logic [NUM_LFSR-1:0][WIDTH-1:0]     lfsr_q;
    logic [NUM_LFSR-1:0][WIDTH-1:0]     lfsr_nxt;
    logic [NUM_INPUTS-1:0][WIDTH-1:0]   bx_q;
    logic [WIDTH:0]                     len_q;
    logic [WIDTH:0]                     count_inc;
    logic [NUM_INPUTS-1:0]              xs_nxt;
    logic                               accept;
    logic                               emit;

    for (genvar g = 0; g < NUM_LFSR; g++) begin : g_step
        assign lfsr_nxt[g] = lfsr_step(lfsr_q[g]);
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        if (CORR_MODE != 0) begin : g_shared
            assign xs_nxt[i] = lfsr_nxt[0] < bx_q[i];
        end else begin : g_own
            assign xs_nxt[i] = lfsr_nxt[i] < bx_q[i];
        end
    end

    assign accept    = (state_q == S_IDLE) && start;
    assign emit      = (state_q == S_RUN) && !stop;
    assign count_inc = count + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (len == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (stop)                    state_d = S_DONE;
                else if (count_inc == len_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_LFSR; g++) lfsr_q[g] <= seed_of(g);
            bx_q  <= '0;
            len_q <= '0;
            Xs    <= '0;
            valid <= 1'b0;
            count <= '0;
            ones  <= '0;
        end else if (accept) begin
            for (int g = 0; g < NUM_LFSR; g++) lfsr_q[g] <= seed_of(g);
            bx_q  <= Bxs;
            len_q <= len;
            valid <= 1'b0;
            count <= '0;
            ones  <= '0;
        end else if (emit) begin
            lfsr_q <= lfsr_nxt;
            Xs     <= xs_nxt;
            valid  <= 1'b1;
            count  <= count_inc;
            for (int i = 0; i < NUM_INPUTS; i++)
                ones[i] <= ones[i] + (WIDTH+1)'(xs_nxt[i]);
        end else begin
            // A stopped RUN cycle, DONE, or an idle cycle: nothing emitted.
            valid <= 1'b0;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_sng_et.sv
// Scoreboard bench for lfsr_sng_et: a shared-LFSR 2-channel instance and an
// independent 4-channel instance, checked against hand-derived counts.
module tb_lfsr_sng_et;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic            start_a, stop_a;
    logic [8:0]      len_a;
    logic [1:0][7:0] bxs_a;
    logic [1:0]      xs_a;
    logic            valid_a, busy_a, done_a;
    logic [8:0]      count_a;
    logic [1:0][8:0] ones_a;
    logic [1:0]      dbg_a;

    logic            start_b, stop_b;
    logic [8:0]      len_b;
    logic [3:0][7:0] bxs_b;
    logic [3:0]      xs_b;
    logic            valid_b, busy_b, done_b;
    logic [8:0]      count_b;
    logic [3:0][8:0] ones_b;
    logic [1:0]      dbg_b;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_a_q[$];
    logic [3:0] exp_b_q[$];
    int   n_valid_a = 0;
    int   n_done_a  = 0;
    int   n_valid_b = 0;
    int   n_diff_b  = 0;
    logic corr_chk  = 1'b0;
    logic [1:0] ea;
    logic [3:0] eb;

    lfsr_sng_et #(.WIDTH(8), .NUM_INPUTS(2), .CORR_MODE(1), .SEED_BASE(1), .SEED_STRIDE(37)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .len(len_a), .Bxs(bxs_a), .stop(stop_a),
        .Xs(xs_a), .valid(valid_a), .busy(busy_a), .done(done_a), .count(count_a),
        .ones(ones_a), .dbg_state(dbg_a)
    );

    lfsr_sng_et #(.WIDTH(8), .NUM_INPUTS(4), .CORR_MODE(0), .SEED_BASE(1), .SEED_STRIDE(37)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .len(len_b), .Bxs(bxs_b), .stop(stop_b),
        .Xs(xs_b), .valid(valid_b), .busy(busy_b), .done(done_b), .count(count_b),
        .ones(ones_b), .dbg_state(dbg_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference step: x^8+x^4+x^3+x^2+1 Galois register, zero data input.
    function automatic logic [7:0] nxt(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
    endfunction

    // Monitor: pops one expected word per valid output.
    always @(negedge clk) begin
        if (valid_a) begin
            n_valid_a++;
            if (exp_a_q.size() == 0) begin
                check("a_extra_bit", 32'(exp_a_q.size()), 1);
            end else begin
                ea = exp_a_q.pop_front();
                check("a_xs", 32'(xs_a), 32'(ea));
            end
            if (corr_chk) check("a_corr", 32'(xs_a[0] & ~xs_a[1]), 0);
        end
        if (done_a) n_done_a++;
        if (valid_b) begin
            n_valid_b++;
            if (xs_b != 4'h0 && xs_b != 4'hF) n_diff_b++;
            if (exp_b_q.size() == 0) begin
                check("b_extra_bit", 32'(exp_b_q.size()), 1);
            end else begin
                eb = exp_b_q.pop_front();
                check("b_xs", 32'(xs_b), 32'(eb));
            end
        end
    end

    task automatic push_a(input int nbits, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] s;
        s = 8'd1;
        for (int k = 0; k < nbits; k++) begin
            s = nxt(s);
            exp_a_q.push_back({s < b1, s < b0});
        end
    endtask

    task automatic wait_done_a(output int lat, output logic vat, output logic seen,
                               input int stop_after, input int v0);
        seen = 1'b0; lat = 0; vat = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk); #1;
            if (done_a) begin
                seen = 1'b1; lat = c; vat = valid_a;
            end else if (stop_after >= 0 && (n_valid_a - v0) == stop_after) begin
                stop_a = 1'b1;
            end
        end
        stop_a = 1'b0;
    endtask

    task automatic run_a(input string nm, input int ln, input logic [7:0] b0, input logic [7:0] b1,
                         input int stop_after, input int exp_cnt, input int exp_o0, input int exp_o1);
        int v0, d0, lat, exp_lat;
        logic seen, vat;
        push_a(exp_cnt, b0, b1);
        v0 = n_valid_a;
        d0 = n_done_a;
        @(posedge clk); #1;
        start_a = 1'b1; len_a = 9'(ln); bxs_a = {b1, b0};
        @(posedge clk); #1;
        start_a = 1'b0;
        check({nm, "_busy_e0"}, 32'(busy_a), 1);
        check({nm, "_valid_e0"}, 32'(valid_a), 0);
        wait_done_a(lat, vat, seen, stop_after, v0);
        exp_lat = (ln == 0) ? 0 : ((stop_after >= 0) ? stop_after + 1 : ln);
        check({nm, "_done_seen"}, 32'(seen), 1);
        check({nm, "_done_lat"}, lat, exp_lat);
        check({nm, "_valid_at_done"}, 32'(vat), 32'(ln > 0 && stop_after < 0));
        check({nm, "_count"}, 32'(count_a), exp_cnt);
        check({nm, "_ones0"}, 32'(ones_a[0]), exp_o0);
        check({nm, "_ones1"}, 32'(ones_a[1]), exp_o1);
        check({nm, "_nvalid"}, n_valid_a - v0, exp_cnt);
        @(posedge clk); #1;
        check({nm, "_busy_after"}, 32'(busy_a), 0);
        check({nm, "_done_after"}, 32'(done_a), 0);
        check({nm, "_valid_after"}, 32'(valid_a), 0);
        check({nm, "_done_pulses"}, n_done_a - d0, 1);
        check({nm, "_queue_left"}, 32'(exp_a_q.size()), 0);
        exp_a_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, d0, lat;
        logic seen, vat;
        logic [7:0] sb [4];

        rst_n = 1'b0;
        start_a = 1'b0; stop_a = 1'b0; len_a = '0; bxs_a = '0;
        start_b = 1'b0; stop_b = 1'b0; len_b = '0; bxs_b = '0;
        #12;
        check("rst_xs", 32'(xs_a), 0);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_count", 32'(count_a), 0);
        check("rst_ones", 32'(ones_a), 0);
        check("rst_state", 32'(dbg_a), 0);
        check("rst_b_state", 32'(dbg_b), 0);
        check("rst_b_ones", 32'(ones_b), 0);
        #10;
        rst_n = 1'b1;

        // Full-period runs on the shared source: values 1..255 each appear once.
        run_a("half", 255, 8'd128, 8'd128, -1, 255, 127, 127);
        run_a("zero", 255, 8'd0, 8'd0, -1, 255, 0, 0);
        run_a("full", 255, 8'd255, 8'd255, -1, 255, 254, 254);
        corr_chk = 1'b1;
        run_a("corr", 255, 8'd64, 8'd128, -1, 255, 63, 127);
        corr_chk = 1'b0;
        // First values from seed 1: 2,4,8,16,32,64,128,29,58,116 -> 9 below 128.
        run_a("stop10", 255, 8'd128, 8'd128, 10, 10, 9, 9);
        run_a("stoplast", 5, 8'd128, 8'd128, 4, 4, 4, 4);
        run_a("len0", 0, 8'd128, 8'd128, -1, 0, 0, 0);
        run_a("len1", 1, 8'd3, 8'd2, -1, 1, 1, 0);

        // start held through RUN and DONE; operands changed mid-run.
        push_a(5, 8'd128, 8'd128);
        push_a(3, 8'd0, 8'd0);
        d0 = n_done_a;
        @(posedge clk); #1;
        start_a = 1'b1; len_a = 9'd5; bxs_a = {8'd128, 8'd128};
        @(posedge clk); #1;
        len_a = 9'd3; bxs_a = '0;
        wait_done_a(lat, vat, seen, -1, n_valid_a);
        check("hold_run1_lat", lat, 5);
        check("hold_run1_count", 32'(count_a), 5);
        check("hold_run1_ones", 32'(ones_a[0]), 5);
        @(posedge clk); #1;
        check("hold_idle_busy", 32'(busy_a), 0);
        @(posedge clk); #1;
        start_a = 1'b0;
        check("hold_run2_busy", 32'(busy_a), 1);
        check("hold_run2_count0", 32'(count_a), 0);
        wait_done_a(lat, vat, seen, -1, n_valid_a);
        check("hold_run2_lat", lat, 3);
        check("hold_run2_count", 32'(count_a), 3);
        check("hold_run2_ones", 32'(ones_a[1]), 0);
        @(posedge clk); #1;
        check("hold_busy_end", 32'(busy_a), 0);
        check("hold_done_pulses", n_done_a - d0, 2);
        check("hold_queue_left", 32'(exp_a_q.size()), 0);
        exp_a_q.delete();

        // Reset mid-run at count=7.
        push_a(255, 8'd128, 8'd128);
        v0 = n_valid_a;
        @(posedge clk); #1;
        start_a = 1'b1; len_a = 9'd255; bxs_a = {8'd128, 8'd128};
        @(posedge clk); #1;
        start_a = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk); #1;
            if (n_valid_a - v0 == 7) seen = 1'b1;
        end
        check("mrst_reach7", 32'(count_a), 7);
        d0 = n_done_a;
        rst_n = 1'b0;
        #1;
        check("mrst_xs", 32'(xs_a), 0);
        check("mrst_valid", 32'(valid_a), 0);
        check("mrst_busy", 32'(busy_a), 0);
        check("mrst_done", 32'(done_a), 0);
        check("mrst_count", 32'(count_a), 0);
        check("mrst_ones", 32'(ones_a), 0);
        exp_a_q.delete();
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        check("mrst_no_done", n_done_a - d0, 0);
        run_a("replay", 255, 8'd128, 8'd128, -1, 255, 127, 127);

        // Independent channels, seeds 1, 38, 75, 112.
        for (int i = 0; i < 4; i++) sb[i] = 8'(1 + 37 * i);
        for (int k = 0; k < 255; k++) begin
            logic [3:0] w;
            for (int i = 0; i < 4; i++) begin
                sb[i] = nxt(sb[i]);
                w[i]  = sb[i] < 8'd128;
            end
            exp_b_q.push_back(w);
        end
        v0 = n_valid_b;
        d0 = n_diff_b;
        @(posedge clk); #1;
        start_b = 1'b1; len_b = 9'd255; bxs_b = {4{8'd128}};
        @(posedge clk); #1;
        start_b = 1'b0;
        seen = 1'b0; vat = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk); #1;
            if (done_b) begin seen = 1'b1; vat = valid_b; end
        end
        check("b_done_seen", 32'(seen), 1);
        check("b_valid_at_done", 32'(vat), 1);
        check("b_count", 32'(count_b), 255);
        for (int i = 0; i < 4; i++) check("b_ones", 32'(ones_b[i]), 127);
        check("b_nvalid", n_valid_b - v0, 255);
        check("b_streams_differ", 32'((n_diff_b - d0) > 0), 1);
        @(posedge clk); #1;
        check("b_busy_after", 32'(busy_b), 0);
        check("b_queue_left", 32'(exp_b_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
